// File: rtl/dot_feeder_if.sv
// rtl/dot_feeder_if.sv - operand-fetch and product-stream bundle for dot_feeder
//
// Purpose: groups the run request, operand-memory read port and the product
// stream that dot_feeder drives into the accumulator.
//
// Signals:
//   start, a_base, b_base, b_stride  run request and addressing (to feeder)
//   rd_en, a_addr, b_addr            operand-memory read strobe and addresses
//   a_rdata, b_rdata                 Q5.10 operands, one cycle after rd_en
//   data, ena                        Q10.21 product and its valid strobe
//   busy, done, sat                  run status
//
// Modports: master = requester/memory side, slave = dot_feeder.
interface dot_feeder_if #(
  parameter int ADDR_W = 4
) ();
  logic              start;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] b_stride;
  logic              rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [15:0]       a_rdata;
  logic [15:0]       b_rdata;
  logic [31:0]       data;
  logic              ena;
  logic              busy;
  logic              done;
  logic              sat;

  modport master (
    output start, a_base, b_base, b_stride, a_rdata, b_rdata,
    input  rd_en, a_addr, b_addr, data, ena, busy, done, sat
  );

  modport slave (
    input  start, a_base, b_base, b_stride, a_rdata, b_rdata,
    output rd_en, a_addr, b_addr, data, ena, busy, done, sat
  );
endinterface

// File: rtl/dot_feeder.sv
// rtl/dot_feeder.sv - walks an A row and a B column and streams Q10.21 products
//
// Purpose: on each accepted start, issues DIM reads (A at a_base+k, B at
// b_base+k*b_stride), multiplies each returned Q5.10 pair and emits one
// registered, saturated Q10.21 product per cycle with a one-cycle ena.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   dot_feeder_if.slave (request, memory read port, product stream)
//
// Timing: start accepted at edge 0 -> rd_en cycles 1..DIM -> ena cycles
// 3..DIM+2, done with the last ena, busy cycles 1..DIM+2.
module dot_feeder #(
  parameter int DIM    = 3,
  parameter int ADDR_W = 4
) (
  input logic         clk,
  input logic         rst,
  dot_feeder_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int            KW     = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(DIM - 1);

  logic [1:0]        state_q,  state_d;
  logic [KW-1:0]     k_q,      k_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic              rd_en_q,  rd_en_d;
  logic [ADDR_W-1:0] a_addr_q, a_addr_d;
  logic [ADDR_W-1:0] b_addr_q, b_addr_d;
  logic              v1_q,     v1_d;
  logic              v1_last_q, v1_last_d;
  logic [31:0]       data_q,   data_d;
  logic              ena_q,    ena_d;
  logic              done_q,   done_d;
  logic              sat_q,    sat_d;

  // Q5.10 x Q5.10 -> Q11.20. The result fits Q10.21 only when the two top
  // bits agree; otherwise clamp to the extreme of the product's sign.
  logic signed [31:0] prod;
  logic               prod_ovf;
  logic [31:0]        prod_fmt;

  assign prod     = $signed(bus.a_rdata) * $signed(bus.b_rdata);
  assign prod_ovf = prod[31] ^ prod[30];
  assign prod_fmt = prod_ovf ? (prod[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                             : {prod[30:0], 1'b0};

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    stride_d  = stride_q;
    rd_en_d   = 1'b0;
    a_addr_d  = a_addr_q;
    b_addr_d  = b_addr_q;
    data_d    = data_q;
    sat_d     = sat_q;

    // Read data is valid the cycle after rd_en; the product lands one
    // cycle later. The last-element marker rides the same pipeline so done
    // lines up with the final ena.
    v1_d      = rd_en_q;
    v1_last_d = rd_en_q && (k_q == K_LAST);
    ena_d     = v1_q;
    done_d    = v1_last_q;

    if (v1_q) begin
      data_d = prod_fmt;
      if (prod_ovf) begin
        sat_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_READ;
          k_d      = '0;
          stride_d = bus.b_stride;
          rd_en_d  = 1'b1;
          a_addr_d = bus.a_base;
          b_addr_d = bus.b_base;
          sat_d    = 1'b0;
        end
      end
      S_READ: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          // B column walk is an accumulated stride, no multiplier.
          k_d      = k_q + 1'b1;
          rd_en_d  = 1'b1;
          a_addr_d = a_addr_q + 1'b1;
          b_addr_d = b_addr_q + stride_q;
        end
      end
      S_DRAIN: begin
        if (done_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      stride_q  <= '0;
      rd_en_q   <= 1'b0;
      a_addr_q  <= '0;
      b_addr_q  <= '0;
      v1_q      <= 1'b0;
      v1_last_q <= 1'b0;
      data_q    <= '0;
      ena_q     <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      stride_q  <= stride_d;
      rd_en_q   <= rd_en_d;
      a_addr_q  <= a_addr_d;
      b_addr_q  <= b_addr_d;
      v1_q      <= v1_d;
      v1_last_q <= v1_last_d;
      data_q    <= data_d;
      ena_q     <= ena_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
    end
  end

  assign bus.rd_en  = rd_en_q;
  assign bus.a_addr = a_addr_q;
  assign bus.b_addr = b_addr_q;
  assign bus.data   = data_q;
  assign bus.ena    = ena_q;
  assign bus.done   = done_q;
  assign bus.sat    = sat_q;
  assign bus.busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_dot_feeder.sv
// tb/tb_dot_feeder.sv - randomized self-checking bench for dot_feeder
module tb_dot_feeder;

  localparam int DIM    = 3;
  localparam int ADDR_W = 4;
  localparam int MEM    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  dot_feeder #(.DIM(DIM), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem_a [MEM];
  logic [15:0] mem_b [MEM];
  logic [15:0] ard = '0;
  logic [15:0] brd = '0;

  // Synchronous-read operand memories: data one cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      ard <= mem_a[bus.a_addr];
      brd <= mem_b[bus.b_addr];
    end
  end
  assign bus.a_rdata = ard;
  assign bus.b_rdata = brd;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Real-valued product in units of 2^-20, clamped to the Q10.21 range.
  task automatic ref_prod(input logic [15:0] a, input logic [15:0] b,
                          output logic [31:0] d, output bit s);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    if (p >= 64'sd1073741824) begin
      d = 32'h7FFF_FFFF; s = 1'b1;
    end else if (p < -64'sd1073741824) begin
      d = 32'h8000_0000; s = 1'b1;
    end else begin
      d = 32'(p * 2); s = 1'b0;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < MEM; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
  endtask

  task automatic run_dot(input int ab, input int bb, input int st, input bit poke);
    logic [31:0] exp_d [DIM];
    bit          exp_s [DIM];
    bit          satm;
    bit          ena_e;
    for (int k = 0; k < DIM; k++)
      ref_prod(mem_a[(ab + k) % MEM], mem_b[(bb + k * st) % MEM], exp_d[k], exp_s[k]);
    @(negedge clk);
    chk("idle_busy", bus.busy, 0);
    chk("idle_ena", bus.ena, 0);
    bus.start    = 1'b1;
    bus.a_base   = ADDR_W'(ab);
    bus.b_base   = ADDR_W'(bb);
    bus.b_stride = ADDR_W'(st);
    satm = 1'b0;
    for (int cyc = 1; cyc <= DIM + 2; cyc++) begin
      @(negedge clk);
      bus.start = poke && (cyc == 2);
      if (poke && cyc == 2) begin
        bus.a_base   = ADDR_W'($urandom);
        bus.b_base   = ADDR_W'($urandom);
        bus.b_stride = ADDR_W'($urandom);
      end
      chk("busy", bus.busy, 1);
      chk("rd_en", bus.rd_en, (cyc <= DIM) ? 1 : 0);
      if (cyc <= DIM) begin
        chk("a_addr", bus.a_addr, (ab + cyc - 1) % MEM);
        chk("b_addr", bus.b_addr, (bb + (cyc - 1) * st) % MEM);
      end
      ena_e = (cyc >= 3);
      if (ena_e) begin
        last_data = exp_d[cyc - 3];
        satm      = satm | exp_s[cyc - 3];
      end
      chk("ena", bus.ena, ena_e);
      chk("data", bus.data, last_data);
      chk("done", bus.done, (cyc == DIM + 2) ? 1 : 0);
      chk("sat", bus.sat, satm);
    end
    bus.start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_en"}, bus.rd_en, 0);
    chk({tag, "_ena"}, bus.ena, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_sat"}, bus.sat, 0);
    chk({tag, "_data"}, bus.data, 0);
    chk({tag, "_a_addr"}, bus.a_addr, 0);
    chk({tag, "_b_addr"}, bus.b_addr, 0);
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b0;
    bus.start = 1'b0; bus.a_base = '0; bus.b_base = '0; bus.b_stride = '0;
    last_data = '0;
    clear_mem();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;

    // Identity row against an all-ones column (row-major B, j=0).
    mem_a[0] = 16'h0400; mem_a[1] = 16'h0000; mem_a[2] = 16'h0000;
    mem_b[0] = 16'h0400; mem_b[3] = 16'h0400; mem_b[6] = 16'h0400;
    run_dot(0, 0, 3, 1'b0);
    chk("ident_last", last_data, 32'h0000_0000);

    // Signed formatting, then saturation, then sat cleared by next start.
    clear_mem();
    mem_a[0] = 16'h0A00; mem_b[0] = 16'hFA00;
    mem_a[8] = 16'h8000; mem_b[8] = 16'h8000;
    run_dot(0, 0, 3, 1'b0);
    run_dot(8, 8, 1, 1'b0);
    chk("sat_val", last_data, 32'h0000_0000);
    run_dot(0, 0, 3, 1'b0);

    // Addressing with start poked while busy, back-to-back.
    for (int i = 0; i < MEM; i++) begin
      mem_a[i] = 16'(i * 16'h0100);
      mem_b[i] = 16'(16'h0040 - i * 16'h0010);
    end
    run_dot(3, 1, 3, 1'b1);
    run_dot(3, 1, 3, 1'b0);

    // Reset mid-run aborts with all outputs low and no done.
    @(negedge clk);
    bus.start = 1'b1; bus.a_base = 4'd2; bus.b_base = 4'd5; bus.b_stride = 4'd3;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    check_zero("midrst_hold");
    rst = 1'b1;
    last_data = '0;
    run_dot(2, 5, 3, 1'b0);

    // Randomized runs mixing small and full-range operands.
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < MEM; i++) begin
        v = 16'($urandom);
        if ($urandom_range(0, 2) != 0) v = {{6{v[9]}}, v[9:0]};
        mem_a[i] = v;
        v = 16'($urandom);
        if ($urandom_range(0, 2) != 0) v = {{6{v[9]}}, v[9:0]};
        mem_b[i] = v;
      end
      run_dot($urandom_range(0, MEM - 1), $urandom_range(0, MEM - 1),
              $urandom_range(0, MEM - 1), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    @(negedge clk);
    chk("end_ena", bus.ena, 0);
    chk("end_busy", bus.busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot_feeder.md
Name: dot_feeder

Overview:
- Upstream stage of the matrix-multiply datapath. Each `start` runs one dot product of length DIM.
- Walks one row of A and one column of B in the operand memories and multiplies element pairs.
- Streams the Q10.21 products into the accumulator: `data` [10:-21] plus a one-cycle `ena` per product.
- Emits exactly DIM `ena` pulses per dot product, which is the count at which the accumulator raises its own flag and self-clears.

Parameters:
- DIM, default 3: dot-product length; number of products emitted per `start`.
- ADDR_W, default 4: operand-memory address width. Must satisfy ADDR_W >= $clog2(DIM*DIM).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a dot product; sampled only in IDLE.
- a_base  input  ADDR_W  address of A[i][0]; sampled when start is accepted.
- b_base  input  ADDR_W  address of B[0][j]; sampled when start is accepted.
- b_stride  input  ADDR_W  B address increment per element (DIM for row-major B); sampled at start.
- rd_en  output  1  read strobe to both operand memories.
- a_addr  output  ADDR_W  A read address.
- b_addr  output  ADDR_W  B read address.
- a_rdata  input  16  signed A element, Q5.10 [5:-10]; valid one cycle after rd_en.
- b_rdata  input  16  signed B element, Q5.10 [5:-10]; valid one cycle after rd_en.
- data  output  32  signed product, Q10.21 [10:-21], registered.
- ena  output  1  data valid, one cycle per product.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse, coincident with the last ena.
- sat  output  1  sticky: some product in the current run saturated.

Behaviour:
- Reset (asynchronous, rst=0): FSM to IDLE. All outputs 0: rd_en, ena, busy, done, sat, data, a_addr, b_addr. Element counter k and both pipeline valid bits cleared.
- FSM states: IDLE, READ, DRAIN.
- IDLE -> READ:
  - start=1 latches the base addresses and stride.
  - Sets k=0 and clears sat.
- READ, each cycle:
  - rd_en=1, a_addr = a_base+k, b_addr = b_base + k*b_stride. Implement the B address as an accumulated adder, not a multiplier.
  - k increments; after k=DIM-1 go to DRAIN.
  - READ lasts exactly DIM cycles.
- Pipeline:
  - Stage 1: rdata returns one cycle after rd_en, valid bit v1.
  - Stage 2: product registered; drives data and ena.
  - Latency: start accepted at edge 0 -> first rd_en in cycle 1 -> first ena in cycle 3. Last ena in cycle DIM+2.
- DRAIN:
  - Waits until the last product is emitted.
  - done=1 in the same cycle as the last ena.
  - Returns to IDLE on the next edge; busy drops with it.
- Back-to-back: start may be asserted in the cycle after done. There is no gap requirement beyond that.
- start while busy: ignored. No queueing, no effect on the current run.
- Arithmetic:
  - p = signed(a_rdata) * signed(b_rdata), full 32-bit product in [11:-20].
  - If p[11]==p[10]: data = {p[10:-20], 1'b0}. Exact, no rounding loss.
  - Else saturate: data = 32'h7FFF_FFFF if p[11]=0, 32'h8000_0000 if p[11]=1. sat is set and held until the next accepted start.
- ena is never high outside a run. Between products data holds its last value.
- Reset mid-run aborts immediately. Any in-flight product is discarded; no partial done.
- DIM=1: one read, one ena, done with it.

Test Plan:
- Identity: DIM=3, A row = {1.0, 0, 0} (16'h0400, 0, 0), B col = {1.0, 1.0, 1.0}.
  -> ena at cycles 3, 4, 5; data = 32'h0020_0000, 0, 0.
  -> done with the third ena; busy high cycles 1-5; sat=0.
- Sign/format: a = 2.5 (16'h0A00), b = -1.5 (16'hFA00).
  -> data = 32'hFF88_0000 (-3.75); sat=0.
- Saturation:
  - a = b = -32.0 (16'h8000) -> p = +1024, data = 32'h7FFF_FFFF, sat=1.
  - Next start clears sat.
- Addressing: a_base=3, b_base=1, b_stride=3, DIM=3.
  -> a_addr 3, 4, 5 and b_addr 1, 4, 7 on consecutive rd_en cycles.
- start while busy at cycle 2: ignored; still exactly 3 ena pulses. start in the cycle after done: new run begins, first ena 3 cycles later.
- rst=0 asserted in cycle 4 of a run: all outputs 0 immediately, no done. A fresh start afterward yields the full DIM ena pulses.
